serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_adder_ctrl_debounce.sv | 40 ++++
 rtl/serial_adder_ctrl.sv | 100 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the serial adder controller and its datapath.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int SUM_WIDTH     = DEFAULT_WIDTH + 1;

endpackage

// File: rtl/serial_adder_ctrl_debounce.sv
// go_debounce: 2-flop synchronizer plus stability counter for a button-driven go.
// The filtered level changes only after CYCLES consecutive samples differing from it.
module go_debounce #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    output logic go_stable
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // go_stable resets high so a button held through reset is not seen as a new press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            go_stable <= 1'b1;
        end else begin
            sync1 <= go;
            sync2 <= sync1;
            if (sync2 == go_stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                go_stable <= sync2;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Control FSM for a bit-serial adder: IDLE -> LOAD -> SHIFT x WIDTH -> DONE.
// Define SERIAL_CTRL_DEBOUNCE_EN to filter go through go_debounce; otherwise go is registered once.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    output logic       load,
    output logic       enable,
    output logic       busy,
    output logic       done,
    output logic [1:0] state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic          go_acc;
    logic          go_q;
    logic          start;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

`ifdef SERIAL_CTRL_DEBOUNCE_EN
    go_debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_go_debounce (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .go_stable(go_acc)
    );
`else
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;

    always_ff @(posedge clk) begin
        if (rst) go_acc <= 1'b1;
        else     go_acc <= go;
    end
`endif

    // go_q resets high: a level held through reset release never looks like a rising edge.
    always_ff @(posedge clk) begin
        if (rst) go_q <= 1'b1;
        else     go_q <= go_acc;
    end

    assign start = go_acc & ~go_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Counter parks at LAST on exit so it never exceeds WIDTH-1.
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (start) state_d = ST_LOAD;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign load   = (state_q == ST_LOAD);
    assign enable = (state_q == ST_SHIFT);
    assign busy   = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign state  = state_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: each cycle's {state, load, enable, busy, done}
// is compared against a hand-built expected trace held in exp_q.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;
    localparam int DB    = 4;
`ifdef SERIAL_CTRL_DEBOUNCE_EN
    localparam int PRE = 2 + DB;
`else
    localparam int PRE = 1;
`endif

    localparam logic [5:0] O_IDLE  = {2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [5:0] O_LOAD  = {2'd1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [5:0] O_SHIFT = {2'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [5:0] O_DONE  = {2'd3, 1'b0, 1'b0, 1'b0, 1'b1};

    logic       clk;
    logic       rst;
    logic       go;
    logic       load;
    logic       enable;
    logic       busy;
    logic       done;
    logic [1:0] state;
    logic [5:0] obs;

    logic [5:0] exp_q[$];
    int         checks;
    int         failures;
    int         en_cnt;

    serial_adder_ctrl #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .go    (go),
        .load  (load),
        .enable(enable),
        .busy  (busy),
        .done  (done),
        .state (state)
    );

    assign obs = {state, load, enable, busy, done};

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push(input logic [5:0] o, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(o);
    endfunction

    // Scoreboard drain: one expected entry per cycle, sampled at the falling edge.
    task automatic drain(input string tag);
        logic [5:0] e;
        en_cnt = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            if (enable) en_cnt++;
            check(tag, {26'd0, obs}, {26'd0, e});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        go       = 1'b1;

        // Reset held 2 cycles with go high, then released with go still high.
        push(O_IDLE, 2);
        drain("reset");
        rst = 1'b0;
        push(O_IDLE, 20);
        drain("go_held_through_reset");

        // Let go settle low, then a single rising edge with a re-pulse during SHIFT.
        go = 1'b0;
        push(O_IDLE, PRE + 2);
        drain("settle_low");
        go = 1'b1;
        push(O_IDLE, PRE);
        push(O_LOAD, 1);
        push(O_SHIFT, WIDTH);
        push(O_DONE, 4);
        fork
            drain("first_add");
            begin
                repeat (PRE + 2) @(negedge clk);
                go = 1'b0;
                repeat (2) @(negedge clk);
                go = 1'b1;
            end
        join
        check("first_add_enable_count", en_cnt, WIDTH);

        // From DONE: release go (done holds), then press again for a back-to-back add.
        go = 1'b0;
        push(O_DONE, PRE + 2);
        drain("done_hold");
        go = 1'b1;
        push(O_DONE, PRE);
        push(O_LOAD, 1);
        push(O_SHIFT, WIDTH);
        push(O_DONE, 2);
        drain("second_add");
        check("second_add_enable_count", en_cnt, WIDTH);

        // Reset during the 4th enable cycle aborts the addition.
        go = 1'b0;
        push(O_DONE, PRE + 2);
        drain("done_hold2");
        go = 1'b1;
        push(O_DONE, PRE);
        push(O_LOAD, 1);
        push(O_SHIFT, 4);
        drain("third_add_start");
        rst = 1'b1;
        push(O_IDLE, 1);
        drain("reset_mid_shift");
        rst = 1'b0;
        push(O_IDLE, 12);
        drain("no_done_after_abort");

`ifdef SERIAL_CTRL_DEBOUNCE_EN
        // Glitching go is rejected; a settled high is accepted after 2+DB+1 cycles.
        go = 1'b0;
        push(O_IDLE, PRE + 2);
        drain("db_settle_low");
        push(O_IDLE, 20);
        fork
            drain("db_glitch");
            begin
                for (int i = 0; i < 10; i++) begin
                    go = ~go;
                    repeat (2) @(negedge clk);
                end
            end
        join
        go = 1'b1;
        push(O_IDLE, 2 + DB);
        push(O_LOAD, 1);
        push(O_SHIFT, WIDTH);
        push(O_DONE, 2);
        drain("db_settled_add");
        check("db_enable_count", en_cnt, WIDTH);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
